// File: rtl/pipe_latch_skid_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and default payload field indices.
package pipe_latch_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int FIELD_PC   = 0;
  localparam int FIELD_INSN = 1;
  localparam int FIELD_A    = 2;
  localparam int FIELD_B    = 3;

  // Occupancy of the stage for a given state.
  function automatic logic [1:0] state_count(skid_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a load-enabled register with asynchronous active-low clear.
module pipe_entry_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/pipe_latch_skid.sv
// Two-entry skid pipeline latch: MAIN drives the output, SKID absorbs one entry when the
// downstream stalls, so in_ready never depends combinationally on out_ready.
module pipe_latch_skid #(
  parameter int               WIDTH  = 32,
  parameter int               FIELDS = 4,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FIELDS*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FIELDS*WIDTH-1:0] out_data,
  output logic [1:0]              count,
  output logic [1:0]              dbg_state
);
  import pipe_latch_skid_pkg::*;

  localparam int DW = FIELDS * WIDTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and ready is a pure decode of the registered state.
  skid_state_e state_q, state_d;
  logic        accept, drain;
  logic        main_load, skid_load, main_sel_skid;
  logic [DW-1:0] main_q, skid_q, main_d;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign count     = state_count(state_q);
  assign dbg_state = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush clears only the state; data registers keep their contents.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    skid_load     = 1'b0;
    main_sel_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d       = ST_ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  pipe_entry_reg #(.W(DW)) u_main (
    .clk    (clock),
    .rst_n  (reset),
    .load_i (main_load),
    .data_i (main_d),
    .data_o (main_q)
  );

  pipe_entry_reg #(.W(DW)) u_skid (
    .clk    (clock),
    .rst_n  (reset),
    .load_i (skid_load),
    .data_i (in_data),
    .data_o (skid_q)
  );

  assign out_data = out_valid ? main_q : {FIELDS{BUBBLE}};

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Directed bench for pipe_latch_skid: a queue-based reference of the two-entry stage,
// plus a narrow instance with a non-zero bubble value.
module tb_pipe_latch_skid;

  logic         clock;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [1:0]   count;
  logic [1:0]   dbg_state;

  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]  b_in_data, b_out_data;
  logic [1:0]   b_count, b_dbg_state;

  logic [127:0] exp_q[$];
  int           tests;
  int           failed;
  int           drained;

  pipe_latch_skid dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .dbg_state (dbg_state)
  );

  pipe_latch_skid #(.WIDTH(8), .FIELDS(2), .BUBBLE(8'h13)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .count     (b_count),
    .dbg_state (b_dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the drain and accept seen before the edge, then check the state after it.
  task automatic tick();
    int sz;
    logic [127:0] exp;
    sz = exp_q.size();
    if (out_valid && out_ready) begin
      if (sz == 0) begin
        chk("drain_from_empty", {127'd0, out_valid}, 128'd0);
      end else begin
        exp = exp_q.pop_front();
        chk("drain_data", out_data, exp);
        drained++;
      end
    end
    if (flush) exp_q.delete();
    else if (in_valid && sz < 2) exp_q.push_back(in_data);
    @(posedge clock);
    #1;
    chk("count", {126'd0, count}, 128'(exp_q.size()));
    chk("out_valid", {127'd0, out_valid}, {127'd0, exp_q.size() != 0});
    chk("in_ready", {127'd0, in_ready}, {127'd0, exp_q.size() < 2});
    if (exp_q.size() == 0) chk("bubble", out_data, 128'd0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] e1, e2, e3, fx;
    tests = 0; failed = 0; drained = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #3;
    chk("rst_count", {126'd0, count}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_data", out_data, 128'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single transfer, one-cycle latency.
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = {32'hB, 32'hA, 32'h8, 32'h4};
    tick();
    chk("first_valid", {127'd0, out_valid}, 128'd1);
    chk("first_data", out_data, {32'hB, 32'hA, 32'h8, 32'h4});
    chk("first_count", {126'd0, count}, 128'd1);
    in_valid = 1'b0;
    tick();

    // Stall: E1, E2 fill the stage, E3 waits upstream, then all drain in order.
    e1 = rnd128(); e2 = rnd128(); e3 = rnd128();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = e1; tick();
    in_data = e2; tick();
    in_data = e3; tick();
    chk("stall_count", {126'd0, count}, 128'd2);
    chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
    chk("stall_head", out_data, e1);
    out_ready = 1'b1;
    tick();
    chk("no_gap_e2", out_data, e2);
    tick();
    chk("no_gap_e3", out_data, e3);
    in_valid = 1'b0;
    tick();

    // Flush from FULL with a new entry offered; that entry must never appear.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = rnd128(); tick();
    in_data = rnd128(); tick();
    fx = rnd128();
    flush = 1'b1; in_data = fx;
    tick();
    chk("flush_count", {126'd0, count}, 128'd0);
    chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_out_data", out_data, 128'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // Streaming: accept and drain every cycle.
    in_valid = 1'b1; in_data = rnd128();
    tick();
    drained = 0;
    for (int i = 0; i < 100; i++) begin
      in_data = rnd128();
      tick();
    end
    chk("stream_drained", 128'(drained), 128'd100);
    chk("stream_count", {126'd0, count}, 128'd1);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset between edges while FULL.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = rnd128(); tick();
    in_data = rnd128(); tick();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_count", {126'd0, count}, 128'd0);
    chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("arst_out_data", out_data, 128'd0);
    exp_q.delete();
    #1 reset = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = rnd128();
    tick();
    in_valid = 1'b0;
    tick();

    // Narrow instance with a non-zero bubble.
    chk("b_idle", {112'd0, b_out_data}, 128'h1313);
    b_in_valid = 1'b1; b_in_data = 16'hBEEF;
    @(posedge clock); #1;
    b_in_valid = 1'b0;
    chk("b_valid", {127'd0, b_out_valid}, 128'd1);
    chk("b_data", {112'd0, b_out_data}, 128'hBEEF);
    b_out_ready = 1'b1;
    @(posedge clock); #1;
    chk("b_idle_after", {112'd0, b_out_data}, 128'h1313);
    chk("b_count", {126'd0, b_count}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
